// File: rtl/cam_capture_ctrl_pkg.sv
// Shared encodings for the camera frame-capture sequencer.
package cam_ctrl_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  localparam int ERR_SHORT     = 0;
  localparam int ERR_LONG      = 1;
  localparam int ERR_EARLY_SOF = 2;
  localparam int ERR_BAD_CFG   = 3;

  localparam int SOF_BIT = 0;
endpackage

// File: rtl/cam_capture_ctrl_if.sv
// AXI4-Stream video link; master drives payload, slave drives ready.
interface cam_capture_ctrl_if #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cam_capture_ctrl_geom.sv
// Pixel/line position tracking and per-beat geometry checks against latched frame size.
module cam_geom_checker #(
  parameter int DIM_WIDTH = 12
) (
  input  logic                 axis_clk,
  input  logic                 rst,
  input  logic                 beat_i,
  input  logic                 first_i,
  input  logic                 tlast_i,
  input  logic                 sof_i,
  input  logic [DIM_WIDTH-1:0] cfg_width_i,
  input  logic [DIM_WIDTH-1:0] cfg_height_i,
  output logic                 eol_ok_o,
  output logic                 short_o,
  output logic                 long_o,
  output logic                 frame_end_o,
  output logic                 early_sof_o
);
  logic [DIM_WIDTH-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [DIM_WIDTH-1:0] x_cur, y_cur, w_eff, h_eff, x_inc, y_inc;
  logic                 at_end;

  // The first beat is checked against the live config before it is latched.
  assign x_cur = first_i ? '0 : x_q;
  assign y_cur = first_i ? '0 : y_q;
  assign w_eff = first_i ? cfg_width_i : w_q;
  assign h_eff = first_i ? cfg_height_i : h_q;
  assign x_inc = x_cur + 1'b1;
  assign y_inc = y_cur + 1'b1;
  assign at_end = (x_inc == w_eff);

  assign eol_ok_o    = tlast_i & at_end;
  assign short_o     = tlast_i & ~at_end;
  assign long_o      = ~tlast_i & at_end;
  assign frame_end_o = eol_ok_o & (y_inc == h_eff);
  assign early_sof_o = sof_i & ~first_i;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    if (beat_i) begin
      x_d = eol_ok_o ? '0 : x_inc;
      y_d = eol_ok_o ? y_inc : y_cur;
      if (first_i) begin
        w_d = cfg_width_i;
        h_d = cfg_height_i;
      end
    end
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      w_q <= w_d;
      h_q <= h_d;
    end
  end
endmodule

// File: rtl/cam_capture_ctrl.sv
// Frame-capture sequencer: gates whole frames from the receiver to the DMA.
// state    | meaning
// IDLE     | discard, wait for ctrl_start
// ARMED    | discard, pass the next SOF beat and start the frame
// CAPTURE  | pass beats, check geometry
// ABORT    | discard until SOF (SOF held, not consumed)
module cam_capture_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter int DIM_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  axis_clk,
  input  logic                  rst,
  cam_capture_ctrl_if.slave     s_axis,
  cam_capture_ctrl_if.master    m_axis,
  input  logic [DIM_WIDTH-1:0]  cfg_width,
  input  logic [DIM_WIDTH-1:0]  cfg_height,
  input  logic                  cfg_continuous,
  input  logic                  ctrl_start,
  input  logic                  ctrl_stop,
  input  logic                  err_clr,
  output logic                  busy,
  output logic                  frame_done,
  output logic [3:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  drop_count
);
  logic [1:0]           state_q, state_d, after_beat;
  logic                 stop_pend_q, stop_pend_d;
  logic [3:0]           err_q, err_d, err_new;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
  logic sof, armed_take, pass, abort_hold, s_ready, beat, chk_beat;
  logic eol_ok, short_line, long_line, frame_end, early_sof;
  logic err_beat, good, cfg_zero, continue_ok;

  assign sof        = s_axis.tuser[SOF_BIT];
  // A stop in the same cycle as the arming SOF leaves that beat undelivered.
  assign armed_take = (state_q == ST_ARMED) & sof & ~ctrl_stop;
  assign pass       = (state_q == ST_CAPTURE) | armed_take;
  assign abort_hold = (state_q == ST_ABORT) & s_axis.tvalid & sof;
  assign s_ready    = pass ? m_axis.tready : ~abort_hold;
  assign beat       = s_axis.tvalid & s_ready;
  assign chk_beat   = pass & beat;

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = pass & s_axis.tvalid;
  assign m_axis.tdata  = DATA_WIDTH'(s_axis.tdata);
  assign m_axis.tuser  = USER_WIDTH'(s_axis.tuser);
  assign m_axis.tlast  = s_axis.tlast | (pass & long_line);

  cam_geom_checker #(.DIM_WIDTH(DIM_WIDTH)) u_geom (
    .axis_clk     (axis_clk),
    .rst          (rst),
    .beat_i       (chk_beat),
    .first_i      (armed_take),
    .tlast_i      (s_axis.tlast),
    .sof_i        (sof),
    .cfg_width_i  (cfg_width),
    .cfg_height_i (cfg_height),
    .eol_ok_o     (eol_ok),
    .short_o      (short_line),
    .long_o       (long_line),
    .frame_end_o  (frame_end),
    .early_sof_o  (early_sof)
  );

  assign err_beat    = chk_beat & (short_line | long_line | early_sof);
  assign good        = chk_beat & frame_end & ~early_sof;
  assign cfg_zero    = (cfg_width == '0) | (cfg_height == '0);
  assign continue_ok = cfg_continuous & ~stop_pend_q & ~ctrl_stop;
  assign after_beat  = err_beat ? ST_ABORT :
                       good     ? (continue_ok ? ST_ARMED : ST_IDLE) : ST_CAPTURE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ctrl_start && !ctrl_stop && !cfg_zero) state_d = ST_ARMED;
      ST_ARMED:   if (ctrl_stop) state_d = ST_IDLE;
                  else if (chk_beat) state_d = after_beat;
      ST_CAPTURE: if (chk_beat) state_d = after_beat;
      ST_ABORT:   if (ctrl_stop) state_d = ST_IDLE;
                  else if (abort_hold) state_d = continue_ok ? ST_ARMED : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    err_new                = '0;
    err_new[ERR_SHORT]     = chk_beat & short_line;
    err_new[ERR_LONG]      = chk_beat & long_line;
    err_new[ERR_EARLY_SOF] = chk_beat & early_sof;
    err_new[ERR_BAD_CFG]   = (state_q == ST_IDLE) & ctrl_start & ~ctrl_stop & cfg_zero;
    err_d       = (err_clr ? 4'b0 : err_q) | err_new;
    stop_pend_d = (state_d == ST_IDLE) ? 1'b0
                : stop_pend_q | ((state_q == ST_CAPTURE) & ctrl_stop);
    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(good);
    drop_cnt_d  = drop_cnt_q + CNT_WIDTH'(err_beat);
  end

  always_ff @(posedge axis_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stop_pend_q <= 1'b0;
      err_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign frame_done  = good;
  assign err_flags   = err_q;
  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a frame-position reference model checked every cycle.
module tb_cam_capture_ctrl;
  localparam int DW = 24;
  localparam int UW = 1;
  localparam int DIMW = 12;
  localparam int CW = 16;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_ABORT = 3;

  logic axis_clk = 1'b0;
  logic rst = 1'b1;
  logic [DIMW-1:0] cfg_width, cfg_height;
  logic cfg_continuous, ctrl_start, ctrl_stop, err_clr;
  logic busy, frame_done;
  logic [3:0] err_flags;
  logic [CW-1:0] frame_count, drop_count;
  logic rnd_ready = 1'b0;

  cam_capture_ctrl_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  cam_capture_ctrl_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

  cam_capture_ctrl #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DIM_WIDTH(DIMW), .CNT_WIDTH(CW)) dut (
    .axis_clk       (axis_clk),
    .rst            (rst),
    .s_axis         (s_if),
    .m_axis         (m_if),
    .cfg_width      (cfg_width),
    .cfg_height     (cfg_height),
    .cfg_continuous (cfg_continuous),
    .ctrl_start     (ctrl_start),
    .ctrl_stop      (ctrl_stop),
    .err_clr        (err_clr),
    .busy           (busy),
    .frame_done     (frame_done),
    .err_flags      (err_flags),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  always #5 axis_clk = ~axis_clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position is a linear beat index split into column/row.
  int ms = M_IDLE, k = 0, wl = 0, hl = 0;
  bit sp = 0;
  logic [CW-1:0] m_fc = '0, m_dc = '0;
  logic [3:0] m_err = '0;
  int npass = 0, ndone = 0, done_at = 0;
  logic last_tl = 1'b0;

  always @(posedge axis_clk) begin
    #1;
    m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge axis_clk) begin : compare
    logic v, sof, lst, pass, sready, beat, fbeat, es, el, ee, good, cont;
    logic [3:0] newe;
    int kk, ww, hh, col, row;
    if (rst) begin
      ms = M_IDLE; k = 0; sp = 0; m_fc = '0; m_dc = '0; m_err = '0;
      npass = 0; ndone = 0; done_at = 0; last_tl = 1'b0;
    end else begin
      v = s_if.tvalid; sof = s_if.tuser[0]; lst = s_if.tlast;
      pass = (ms == M_CAP) || (ms == M_ARMED && sof && !ctrl_stop);
      sready = pass ? m_if.tready : !(ms == M_ABORT && v && sof);
      beat = v && sready;
      fbeat = pass && beat;
      kk = (ms == M_ARMED) ? 0 : k;
      ww = (ms == M_ARMED) ? int'(cfg_width) : wl;
      hh = (ms == M_ARMED) ? int'(cfg_height) : hl;
      if (ww < 1) ww = 1;
      col = kk % ww;
      row = kk / ww;
      es = pass && lst && (col != ww - 1);
      el = pass && !lst && (col == ww - 1);
      ee = pass && sof && (ms != M_ARMED);
      good = fbeat && !es && !el && !ee && (col == ww - 1) && (row == hh - 1);

      chk("m_tvalid", m_if.tvalid, pass && v);
      chk("s_tready", s_if.tready, sready);
      chk("frame_done", frame_done, good);
      chk("busy", busy, ms != M_IDLE);
      chk("err_flags", err_flags, m_err);
      chk("frame_count", frame_count, m_fc);
      chk("drop_count", drop_count, m_dc);
      if (pass && v) begin
        chk("m_tdata", m_if.tdata, s_if.tdata);
        chk("m_tuser", m_if.tuser, s_if.tuser);
        chk("m_tlast", m_if.tlast, lst || (col == ww - 1));
      end
      if (m_if.tvalid && m_if.tready) begin
        npass++;
        last_tl = m_if.tlast;
      end
      if (frame_done) begin
        ndone++;
        done_at = npass;
      end

      newe = fbeat ? {1'b0, ee, el, es} : 4'b0;
      if (ms == M_IDLE && ctrl_start && !ctrl_stop && (cfg_width == 0 || cfg_height == 0))
        newe[3] = 1'b1;
      m_err = (err_clr ? 4'b0 : m_err) | newe;
      if (ms == M_CAP && ctrl_stop) sp = 1;
      cont = cfg_continuous && !sp && !ctrl_stop;
      case (ms)
        M_IDLE: if (ctrl_start && !ctrl_stop && cfg_width != 0 && cfg_height != 0) ms = M_ARMED;
        M_ABORT: begin
          if (ctrl_stop) ms = M_IDLE;
          else if (v && sof) ms = cont ? M_ARMED : M_IDLE;
        end
        default: begin
          if (ms == M_ARMED && ctrl_stop) ms = M_IDLE;
          else if (fbeat) begin
            if (ms == M_ARMED) begin wl = ww; hl = hh; end
            if (newe[2:0] != 0) begin ms = M_ABORT; m_dc++; end
            else if (good) begin m_fc++; ms = cont ? M_ARMED : M_IDLE; end
            else begin ms = M_CAP; k = kk + 1; end
          end
        end
      endcase
      if (ms == M_IDLE) sp = 0;
    end
  end

  task automatic beat_tx(input logic [DW-1:0] d, input logic sof, input logic last, input logic stop);
    bit got = 0;
    int n = 0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tuser = sof; s_if.tlast = last;
    ctrl_stop = stop;
    while (!got) begin
      @(negedge axis_clk);
      got = s_if.tready;
      @(posedge axis_clk);
      #1;
      ctrl_stop = 1'b0;
      n++;
      if (!got && n > 40) begin
        checks++; errors++;
        $display("FAIL beat_timeout: no beat after %0d cycles, expected tready", n);
        got = 1;
      end
    end
    s_if.tvalid = 1'b0; s_if.tuser = '0; s_if.tlast = 1'b0;
  endtask

  task automatic send_frame(input int w, input int h, input int base, input int stop_at);
    for (int i = 0; i < w * h; i++)
      beat_tx(DW'(base + i), i == 0, (i % w) == w - 1, i == stop_at);
  endtask

  task automatic do_start();
    ctrl_start = 1'b1; @(posedge axis_clk); #1; ctrl_start = 1'b0;
  endtask
  task automatic do_stop();
    ctrl_stop = 1'b1; @(posedge axis_clk); #1; ctrl_stop = 1'b0;
  endtask
  task automatic do_clr();
    err_clr = 1'b1; @(posedge axis_clk); #1; err_clr = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge axis_clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic settle();
    repeat (2) @(posedge axis_clk);
    #2;
  endtask

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    cfg_width = 12'd4; cfg_height = 12'd2; cfg_continuous = 1'b0;
    ctrl_start = 1'b0; ctrl_stop = 1'b0; err_clr = 1'b0;
    #1;
    chk("rst_m_tvalid", m_if.tvalid, 1'b0);
    chk("rst_s_tready", s_if.tready, 1'b1);
    do_reset();
    chk("rst_frame_count", frame_count, 0);
    chk("rst_busy", busy, 0);

    // single-shot clean frame after junk
    do_start();
    beat_tx(24'hAAAAAA, 1'b0, 1'b0, 1'b0);
    beat_tx(24'hBBBBBB, 1'b0, 1'b1, 1'b0);
    send_frame(4, 2, 24'h10, -1);
    settle();
    chk("t1_frame_count", frame_count, 1);
    chk("t1_npass", npass, 8);
    chk("t1_done_at", done_at, 8);
    chk("t1_busy", busy, 0);

    // continuous, stop during frame 2
    do_reset();
    cfg_continuous = 1'b1;
    do_start();
    send_frame(4, 2, 24'h100, -1);
    send_frame(4, 2, 24'h200, 3);
    send_frame(4, 2, 24'h300, -1);
    settle();
    chk("t2_frame_count", frame_count, 2);
    chk("t2_npass", npass, 16);
    chk("t2_ndone", ndone, 2);
    chk("t2_busy", busy, 0);

    // short line, then recovery in continuous mode
    do_reset();
    do_start();
    beat_tx(24'h1, 1'b1, 1'b0, 1'b0);
    beat_tx(24'h2, 1'b0, 1'b0, 1'b0);
    beat_tx(24'h3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) beat_tx(DW'(24'h40 + i), 1'b0, i == 4, 1'b0);
    send_frame(4, 2, 24'h500, -1);
    settle();
    chk("t3_err_flags", err_flags, 4'b0001);
    chk("t3_drop_count", drop_count, 1);
    chk("t3_frame_count", frame_count, 1);
    chk("t3_npass", npass, 11);
    chk("t3_busy_armed", busy, 1);
    do_stop();
    settle();
    chk("t3_busy_stopped", busy, 0);

    // long line: forced tlast on the 4th beat
    do_reset();
    cfg_continuous = 1'b0;
    do_start();
    for (int i = 0; i < 4; i++) beat_tx(DW'(24'h60 + i), i == 0, 1'b0, 1'b0);
    settle();
    chk("t4_forced_tlast", last_tl, 1);
    chk("t4_npass", npass, 4);
    chk("t4_err_flags", err_flags, 4'b0010);
    chk("t4_busy_abort", busy, 1);
    beat_tx(24'h70, 1'b1, 1'b0, 1'b0);
    settle();
    chk("t4_busy_idle", busy, 0);
    chk("t4_npass_after", npass, 4);

    // bad configuration and error clear
    do_reset();
    cfg_width = 12'd0;
    do_start();
    settle();
    chk("t5_bad_cfg", err_flags, 4'b1000);
    chk("t5_busy", busy, 0);
    do_clr();
    settle();
    chk("t5_cleared", err_flags, 4'b0000);
    ctrl_start = 1'b1; err_clr = 1'b1;
    @(posedge axis_clk); #1;
    ctrl_start = 1'b0; err_clr = 1'b0;
    settle();
    chk("t5_clr_vs_new", err_flags, 4'b1000);

    // random downstream backpressure, then reset mid-frame
    do_reset();
    cfg_width = 12'd4;
    rnd_ready = 1'b1;
    do_start();
    send_frame(4, 2, 24'h800, -1);
    rnd_ready = 1'b0;
    settle();
    chk("t6_frame_count", frame_count, 1);
    chk("t6_npass", npass, 8);
    chk("t6_done_at", done_at, 8);
    do_start();
    for (int i = 0; i < 3; i++) beat_tx(DW'(24'h900 + i), i == 0, 1'b0, 1'b0);
    s_if.tvalid = 1'b1; s_if.tdata = 24'h903;
    #3;
    rst = 1'b1;
    #1;
    chk("t6_rst_m_tvalid", m_if.tvalid, 0);
    chk("t6_rst_frame_count", frame_count, 0);
    chk("t6_rst_busy", busy, 0);
    s_if.tvalid = 1'b0;
    @(posedge axis_clk); #1;
    rst = 1'b0;

    // single-beat frame
    cfg_width = 12'd1; cfg_height = 12'd1;
    do_start();
    beat_tx(24'hC0FFEE, 1'b1, 1'b1, 1'b0);
    settle();
    chk("t7_frame_count", frame_count, 1);
    chk("t7_done_at", done_at, 1);
    chk("t7_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
